// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative vectoring-mode CORDIC: (x, y) -> atan2 angle and gain-compensated magnitude
// Ports: clk, rst (sync active-low), start (one-cycle request, sampled in IDLE),
//        x_in/y_in (signed Q16.16, captured on accept),
//        angle_out (signed Q16.16 degrees, (-180, +180]), mag_out (Q16.16 magnitude),
//        busy (accept cycle until done), done (one-cycle result-valid pulse).
module cordic_vectoring #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] angle_out,
    output logic [WIDTH-1:0] mag_out,
    output logic             busy,
    output logic             done
);
    localparam int DW = WIDTH + 2;
    localparam int PW = DW + 17;
    localparam logic signed [WIDTH-1:0] DEG180   = WIDTH'(11796480);
    localparam logic signed [WIDTH-1:0] DEG360   = WIDTH'(23592960);
    localparam logic signed [PW-1:0]    K_GAIN   = PW'(39797);
    localparam logic signed [PW-1:0]    MAG_MAX  = PW'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
    localparam logic [3:0]              CNT_LAST = 4'(ITER-1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_DONE} state_t;

    state_t                  r_state;
    logic signed [DW-1:0]    r_x, r_y;
    logic signed [WIDTH-1:0] r_z;
    logic [3:0]              r_cnt;
    logic                    r_axis;
    logic [WIDTH-1:0]        r_mag;
    logic [WIDTH-1:0]        r_angle;
    logic [WIDTH-1:0]        r_mag_out;
    logic                    r_busy;
    logic                    r_done;

    logic signed [DW-1:0]    w_x_sh, w_y_sh;
    logic signed [PW-1:0]    w_prod, w_prod_sh;

    // atan(2^-i) in Q16.16 degrees, rounded to nearest
    function automatic logic signed [WIDTH-1:0] atan_tab(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = 32'd2949120;
            4'd1:    v = 32'd1740967;
            4'd2:    v = 32'd919879;
            4'd3:    v = 32'd466945;
            4'd4:    v = 32'd234379;
            4'd5:    v = 32'd117304;
            4'd6:    v = 32'd58666;
            4'd7:    v = 32'd29335;
            4'd8:    v = 32'd14668;
            4'd9:    v = 32'd7334;
            4'd10:   v = 32'd3667;
            4'd11:   v = 32'd1833;
            4'd12:   v = 32'd917;
            4'd13:   v = 32'd458;
            4'd14:   v = 32'd229;
            default: v = 32'd115;
        endcase
        return WIDTH'(v);
    endfunction

    assign w_x_sh    = r_x >>> r_cnt;
    assign w_y_sh    = r_y >>> r_cnt;
    assign w_prod    = $signed({{17{r_x[DW-1]}}, r_x}) * K_GAIN;
    assign w_prod_sh = w_prod >>> 16;

    assign angle_out = r_angle;
    assign mag_out   = r_mag_out;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_cnt     <= '0;
            r_axis    <= 1'b0;
            r_mag     <= '0;
            r_angle   <= '0;
            r_mag_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    // a start seen during the done cycle still counts as "while busy"
                    if (start && !r_done) begin
                        r_x     <= {{2{x_in[WIDTH-1]}}, x_in};
                        r_y     <= {{2{y_in[WIDTH-1]}}, y_in};
                        r_busy  <= 1'b1;
                        r_state <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (r_x[DW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_y[DW-1] ? -DEG180 : DEG180;
                    end else begin
                        r_z <= '0;
                    end
                    // On the x axis the angle is already exact (0 or +180); the
                    // micro-rotations still run so the magnitude gets the same gain,
                    // but z is frozen so it cannot drift (and 0/0 stays at 0).
                    r_axis  <= (r_y == '0);
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    if (!r_y[DW-1]) begin
                        r_x <= r_x + w_y_sh;
                        r_y <= r_y - w_x_sh;
                        if (!r_axis) r_z <= r_z + atan_tab(r_cnt);
                    end else begin
                        r_x <= r_x - w_y_sh;
                        r_y <= r_y + w_x_sh;
                        if (!r_axis) r_z <= r_z - atan_tab(r_cnt);
                    end
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == CNT_LAST) r_state <= S_SCALE;
                end
                S_SCALE: begin
                    // x never decreases during vectoring, so only the top needs clamping
                    r_mag <= (w_prod_sh > MAG_MAX) ? MAG_MAX[WIDTH-1:0] : w_prod_sh[WIDTH-1:0];
                    // residual rotation error can push z just past +-180; fold back into (-180, +180]
                    if (r_z > DEG180)        r_z <= r_z - DEG360;
                    else if (r_z <= -DEG180) r_z <= r_z + DEG360;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_angle   <= r_z;
                    r_mag_out <= r_mag;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring
module tb_cordic_vectoring;
    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic [31:0] angle_out;
    logic [31:0] mag_out;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    cordic_vectoring #(.WIDTH(32), .ITER(16)) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
        .angle_out(angle_out), .mag_out(mag_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        longint      ang;
        longint      ang_tol;
        longint      mag;
        longint      mag_tol;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        checks++;
        if (act - exp > tol || exp - act > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // angle compare that treats -180 and +180 as neighbours
    task automatic chk_ang(input string name, input logic [31:0] a, input longint exp, input longint tol);
        longint d;
        d = longint'($signed(a)) - exp;
        if (d > 64'sd11796480)       d = d - 64'sd23592960;
        else if (d < -64'sd11796480) d = d + 64'sd23592960;
        chk(name, exp + d, exp, tol);
    endtask

    // issue one request, return edges from accept to done; check done is one cycle wide
    task automatic do_op(input logic [31:0] xv, input logic [31:0] yv, output int lat);
        @(negedge clk);
        x_in = xv; y_in = yv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        chk("done_pulse_width", longint'(done), 0, 0);
        chk("busy_after_done", longint'(busy), 0, 0);
    endtask

    initial begin
        int lat, ndone, first;
        int xv, yv;
        real xr, yr, ea, em;

        tbl[0] = '{32'd65536,      32'd0,          0,         328, 65536,      35};
        tbl[1] = '{32'd65536,      32'd65536,      2949120,   328, 92682,      48};
        tbl[2] = '{32'hFFFF0000,   32'hFFFF0000,   -8847360,  328, 92682,      48};
        tbl[3] = '{32'hFFFF0000,   32'd0,          11796480,  0,   65536,      35};
        tbl[4] = '{32'd0,          32'hFFFF0000,   -5898240,  328, 65536,      35};
        tbl[5] = '{32'd0,          32'd0,          0,         0,   0,          0};
        tbl[6] = '{32'd0,          32'd65536,      5898240,   328, 65536,      35};
        tbl[7] = '{32'h80000000,   32'd0,          11796480,  0,   2147483647, 0};
        tbl[8] = '{32'h7FFFFFFF,   32'h7FFFFFFF,   2949120,   328, 2147483647, 0};
        tbl[9] = '{32'h80000000,   32'h80000000,   -8847360,  328, 2147483647, 0};

        repeat (3) @(negedge clk);
        chk("reset_angle", longint'(angle_out), 0, 0);
        chk("reset_mag", longint'(mag_out), 0, 0);
        chk("reset_busy", longint'(busy), 0, 0);
        chk("reset_done", longint'(done), 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].x, tbl[i].y, lat);
            chk($sformatf("vec%0d_latency", i), longint'(lat), 19, 0);
            chk($sformatf("vec%0d_angle", i), longint'($signed(angle_out)), tbl[i].ang, tbl[i].ang_tol);
            chk($sformatf("vec%0d_mag", i), longint'(mag_out), tbl[i].mag, tbl[i].mag_tol);
        end

        // second start during computation must be ignored
        @(negedge clk);
        x_in = 32'd65536; y_in = 32'd65536; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) begin x_in = 32'hFFFF0000; start = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
        end
        start = 1'b0;
        chk("ignore_start_latency", longint'(first), 19, 0);
        chk("ignore_start_done_count", longint'(ndone), 1, 0);
        chk("ignore_start_angle", longint'($signed(angle_out)), 2949120, 328);
        chk("ignore_start_mag", longint'(mag_out), 92682, 48);

        // reset mid-operation
        @(negedge clk);
        x_in = 32'd0; y_in = 32'd65536; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0, 0);
        chk("abort_done", longint'(done), 0, 0);
        chk("abort_angle", longint'(angle_out), 0, 0);
        chk("abort_mag", longint'(mag_out), 0, 0);
        rst = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", longint'(ndone), 0, 0);
        do_op(32'hFFFF0000, 32'd65536, lat);
        chk("after_abort_latency", longint'(lat), 19, 0);
        chk("after_abort_angle", longint'($signed(angle_out)), 8847360, 328);
        chk("after_abort_mag", longint'(mag_out), 92682, 48);

        // random vectors against real-valued atan2 / hypot
        for (int n = 0; n < 24; n++) begin
            do begin
                xv = int'($urandom_range(0, 33554431)) - 16777216;
                yv = int'($urandom_range(0, 33554431)) - 16777216;
            end while (((xv < 0) ? -xv : xv) + ((yv < 0) ? -yv : yv) < 131072);
            xr = xv; yr = yv;
            ea = $atan2(yr, xr) * 180.0 / PI * 65536.0;
            em = $sqrt(xr * xr + yr * yr);
            do_op(xv, yv, lat);
            chk($sformatf("rand%0d_latency", n), longint'(lat), 19, 0);
            chk_ang($sformatf("rand%0d_angle(x=%0d,y=%0d)", n, xv, yv), angle_out, longint'(ea), 328);
            chk($sformatf("rand%0d_mag(x=%0d,y=%0d)", n, xv, yv), longint'(mag_out), longint'(em),
                longint'(em * 0.0005) + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
